// File: rtl/wb_gpio_multi_pkg.sv
// Shared register map and helpers for the multi-port Wishbone GPIO slave.
package wb_gpio_multi_pkg;

  // Register select values (word offset within a port block)
  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_OE     = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_RISE   = 3'd3;
  localparam logic [2:0] REG_FALL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_SET    = 3'd6;
  localparam logic [2:0] REG_CLR    = 3'd7;

  // Byte distance between consecutive port register blocks
  localparam logic [31:0] PORT_STRIDE = 32'h20;
  localparam int          PORT_SHIFT  = $clog2(PORT_STRIDE);

  // Bus FSM states
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;

  // Expand Wishbone byte selects into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// Input synchroniser plus rise/fall detection for one GPIO port.
// Edges are only reported once the top-level priming counter has expired,
// so pads that are already high when reset releases do not look like edges.
module gpio_edge_detect #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             prime,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] prev_reg;

  // Shift pads through the synchroniser chain and keep one cycle of history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_reg[SYNC_STAGES-1];
  assign rise     = prime ? (sync_val & ~prev_reg) : '0;
  assign fall     = prime ? (~sync_val & prev_reg) : '0;

endmodule

// File: rtl/wb_gpio_multi.sv
// Wishbone B4 classic slave with NPORTS 32-bit GPIO ports, atomic set/clear,
// edge interrupts and error termination for unmapped accesses.
module wb_gpio_multi
  import wb_gpio_multi_pkg::*;
#(
  parameter int          NPORTS      = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [NPORTS*32-1:0] gpio_o,
  output logic [NPORTS*32-1:0] gpio_oe_o,
  input  logic [NPORTS*32-1:0] gpio_i,
  output logic                irq_o
);

  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W        = $clog2(PRIME_CYCLES + 1);

  logic             state_reg;
  logic             ack_reg, err_reg, irq_reg;
  logic [31:0]      dat_reg;
  logic [CNT_W-1:0] prime_cnt_reg;
  logic             prime;

  logic [2:0]  port_idx;
  logic [2:0]  reg_sel;
  logic        req, hit, wr_en;
  logic [31:0] wmask, wr_data, rd_data;
  logic [31:0] port_rd [NPORTS];
  logic [NPORTS-1:0] port_irq;

  // Being in RESP is equivalent to ack|err being high, so this is the
  // classic "cyc & stb & !ack & !err" request qualifier.
  assign req      = wb_cyc_i & wb_stb_i & (state_reg == ST_IDLE);
  assign port_idx = wb_adr_i[PORT_SHIFT +: 3];
  assign reg_sel  = wb_adr_i[4:2];
  assign hit      = ((wb_adr_i & ADDR_MASK) == BASE_ADDR) && ({1'b0, port_idx} < 4'(NPORTS));
  assign wr_en    = req & wb_we_i & hit;
  assign wmask    = byte_mask(wb_sel_i);
  assign wr_data  = wb_dat_i & wmask;
  assign prime    = (prime_cnt_reg == CNT_W'(PRIME_CYCLES));

  // Saturating counter that holds off edge detection until the chains are filled
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)  prime_cnt_reg <= '0;
    else if (!prime)  prime_cnt_reg <= prime_cnt_reg + 1'b1;
  end

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    logic [31:0] out_reg, oe_reg, rise_en_reg, fall_en_reg, status_reg;
    logic [31:0] sync_val, rise, fall, w1c;
    logic        port_wr;

    assign port_wr = wr_en && (port_idx == 3'(gi));
    assign w1c     = (port_wr && reg_sel == REG_STATUS) ? wr_data : '0;

    gpio_edge_detect #(
      .WIDTH      (32),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .din     (gpio_i[gi*32 +: 32]),
      .prime   (prime),
      .sync_val(sync_val),
      .rise    (rise),
      .fall    (fall)
    );

    // Byte-masked writes to the configuration and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        out_reg     <= '0;
        oe_reg      <= '0;
        rise_en_reg <= '0;
        fall_en_reg <= '0;
      end else if (port_wr) begin
        case (reg_sel)
          REG_OUT:  out_reg     <= (out_reg & ~wmask) | wr_data;
          REG_OE:   oe_reg      <= (oe_reg & ~wmask) | wr_data;
          REG_RISE: rise_en_reg <= (rise_en_reg & ~wmask) | wr_data;
          REG_FALL: fall_en_reg <= (fall_en_reg & ~wmask) | wr_data;
          REG_SET:  out_reg     <= out_reg | wr_data;
          REG_CLR:  out_reg     <= out_reg & ~wr_data;
          default:  ;
        endcase
      end
    end

    // Sticky edge status; a same-cycle event beats the write-1-to-clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) status_reg <= '0;
      else             status_reg <= (status_reg & ~w1c) | (rise & rise_en_reg) | (fall & fall_en_reg);
    end

    // Per-port read view
    always_comb begin
      port_rd[gi] = '0;
      case (reg_sel)
        REG_OUT:    port_rd[gi] = out_reg;
        REG_OE:     port_rd[gi] = oe_reg;
        REG_IN:     port_rd[gi] = sync_val;
        REG_RISE:   port_rd[gi] = rise_en_reg;
        REG_FALL:   port_rd[gi] = fall_en_reg;
        REG_STATUS: port_rd[gi] = status_reg;
        default:    port_rd[gi] = '0;
      endcase
    end

    assign gpio_o[gi*32 +: 32]    = out_reg;
    assign gpio_oe_o[gi*32 +: 32] = oe_reg;
    assign port_irq[gi]           = |status_reg;
  end

  // Select the addressed port's read view
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (port_idx == 3'(i)) rd_data = port_rd[i];
    end
  end

  // Bus FSM: IDLE takes a request, RESP drives one ack/err cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg <= ST_IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            state_reg <= ST_RESP;
            ack_reg   <= hit;
            err_reg   <= ~hit;
            dat_reg   <= (hit && !wb_we_i) ? rd_data : '0;
          end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            dat_reg <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          dat_reg   <= '0;
        end
      endcase
    end
  end

  // Registered level interrupt from any pending status bit
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) irq_reg <= 1'b0;
    else             irq_reg <= |port_irq;
  end

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_dat_o = dat_reg;
  assign irq_o    = irq_reg;

endmodule

// File: tb/tb_wb_gpio_multi.sv
// Self-checking bench for wb_gpio_multi with a register-level reference model.
module tb_wb_gpio_multi;
  import wb_gpio_multi_pkg::*;

  localparam int          NPORTS = 2;
  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam logic [31:0] MASK   = 32'hFFFF_F000;

  logic                    clk, rst_n, cyc, stb, we;
  logic [31:0]             adr, dat_w, dat_r;
  logic [3:0]              sel;
  logic                    ack, err, irq;
  logic [NPORTS*32-1:0]    gpio_o, gpio_oe_o, gpio_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_out [8], m_oe [8], m_rise [8], m_fall [8], m_status [8];

  wb_gpio_multi #(
    .NPORTS(NPORTS), .BASE_ADDR(BASE), .ADDR_MASK(MASK), .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_dat_o(dat_r), .wb_ack_o(ack), .wb_err_o(err),
    .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .gpio_i(gpio_i), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int p = 0; p < 8; p++) begin
      m_out[p] = 0; m_oe[p] = 0; m_rise[p] = 0; m_fall[p] = 0; m_status[p] = 0;
    end
  endtask

  function automatic logic [NPORTS*32-1:0] exp_gpio_o();
    logic [NPORTS*32-1:0] v;
    for (int p = 0; p < NPORTS; p++) v[p*32 +: 32] = m_out[p];
    return v;
  endfunction

  function automatic logic [NPORTS*32-1:0] exp_gpio_oe();
    logic [NPORTS*32-1:0] v;
    for (int p = 0; p < NPORTS; p++) v[p*32 +: 32] = m_oe[p];
    return v;
  endfunction

  function automatic logic [31:0] pad_events(input logic [31:0] o, input logic [31:0] n, input int p);
    return (n & ~o & m_rise[p]) | (~n & o & m_fall[p]);
  endfunction

  // Spec-level register semantics: decode, mask, update, predict response
  task automatic model_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, output logic eack, output logic eerr,
                              output logic [31:0] erd);
    int p, r;
    logic [31:0] m, dm;
    p = int'(a[7:5]);
    r = int'(a[4:2]);
    m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    dm = d & m;
    eack = 0; eerr = 0; erd = 0;
    if (((a & MASK) != BASE) || p >= NPORTS) begin
      eerr = 1;
    end else begin
      eack = 1;
      if (w) begin
        case (r)
          0: m_out[p]    = (m_out[p] & ~m) | dm;
          1: m_oe[p]     = (m_oe[p] & ~m) | dm;
          3: m_rise[p]   = (m_rise[p] & ~m) | dm;
          4: m_fall[p]   = (m_fall[p] & ~m) | dm;
          5: m_status[p] = m_status[p] & ~dm;
          6: m_out[p]    = m_out[p] | dm;
          7: m_out[p]    = m_out[p] & ~dm;
          default: ;
        endcase
      end else begin
        case (r)
          0: erd = m_out[p];
          1: erd = m_oe[p];
          2: erd = gpio_i[p*32 +: 32];
          3: erd = m_rise[p];
          4: erd = m_fall[p];
          5: erd = m_status[p];
          default: erd = 0;
        endcase
      end
    end
  endtask

  // One bus transfer, started at a negedge; returns after the response cycle
  task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic o_ack, output logic o_err,
                          output logic [31:0] o_dat, output logic o_ack_n, output logic o_err_n);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
    @(posedge clk); #1;
    o_ack = ack; o_err = err; o_dat = dat_r;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    o_ack_n = ack; o_err_n = err;
    @(negedge clk);
  endtask

  // Model + bus together; logs one line per transaction
  task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic o_ack, output logic o_err,
                           output logic [31:0] o_dat, output logic e_ack, output logic e_err,
                           output logic [31:0] e_dat);
    logic an, en;
    model_access(a, w, d, s, e_ack, e_err, e_dat);
    bus_xfer(a, w, d, s, o_ack, o_err, o_dat, an, en);
    $display("[TB] %s adr=%h dat=%h sel=%b -> ack=%b err=%b rdat=%h",
             w ? "WR" : "RD", a, d, s, o_ack, o_err, o_dat);
  endtask

  task automatic test_reset();
    logic a, e, ea, ee;
    logic [31:0] d, ed;
    rst_n = 0; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0; sel = 0;
    gpio_i = '1;
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (gpio_o !== '0 || gpio_oe_o !== '0 || ack !== 0 || err !== 0 || irq !== 0 || dat_r !== 0) begin
      tests_failed++;
      $display("FAIL reset_outputs got gpio_o=%h oe=%h ack=%b err=%b irq=%b dat=%h expected all 0",
               gpio_o, gpio_oe_o, ack, err, irq, dat_r);
    end
    rst_n = 1;
    do_access(BASE + 32'h0C, 1, 32'hFFFF_FFFF, 4'hF, a, e, d, ea, ee, ed);
    do_access(BASE + 32'h2C, 1, 32'hFFFF_FFFF, 4'hF, a, e, d, ea, ee, ed);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (irq !== 1'b0) begin
        tests_failed++;
        $display("FAIL prime_irq cycle=%0d got irq=%b expected 0", k, irq);
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      do_access(BASE + p*PORT_STRIDE + 32'h14, 0, 0, 4'hF, a, e, d, ea, ee, ed);
      tests_run++;
      if (a !== ea || d !== ed) begin
        tests_failed++;
        $display("FAIL prime_status p=%0d got ack=%b dat=%h expected ack=%b dat=%h", p, a, d, ea, ed);
      end
    end
    do_access(BASE + 32'h08, 0, 0, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (a !== 1'b1 || d !== 32'hFFFF_FFFF || d !== ed) begin
      tests_failed++;
      $display("FAIL read_in got ack=%b dat=%h expected ack=1 dat=ffffffff", a, d);
    end
  endtask

  task automatic test_set_clr();
    logic a, e, ea, ee;
    logic [31:0] d, ed;
    do_access(BASE + 32'h20, 1, 32'h0000_00F0, 4'hF, a, e, d, ea, ee, ed);
    do_access(BASE + 32'h38, 1, 32'h0000_000F, 4'hF, a, e, d, ea, ee, ed);
    do_access(BASE + 32'h3C, 1, 32'h0000_0030, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (gpio_o[63:32] !== 32'h0000_00CF || m_out[1] !== 32'h0000_00CF) begin
      tests_failed++;
      $display("FAIL set_clr_pins got %h expected 000000cf", gpio_o[63:32]);
    end
    do_access(BASE + 32'h20, 0, 0, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (a !== 1'b1 || d !== 32'h0000_00CF) begin
      tests_failed++;
      $display("FAIL set_clr_read got ack=%b dat=%h expected ack=1 dat=000000cf", a, d);
    end
  endtask

  task automatic test_byte_sel();
    logic a, e, ea, ee;
    logic [31:0] d, ed;
    do_access(BASE + 32'h00, 1, 32'h0, 4'hF, a, e, d, ea, ee, ed);
    do_access(BASE + 32'h00, 1, 32'hAABB_CCDD, 4'b0010, a, e, d, ea, ee, ed);
    tests_run++;
    if (gpio_o[31:0] !== 32'h0000_CC00 || m_out[0] !== 32'h0000_CC00) begin
      tests_failed++;
      $display("FAIL byte_sel got %h expected 0000cc00", gpio_o[31:0]);
    end
  endtask

  task automatic test_random();
    logic a, e, ea, ee, w;
    logic [31:0] d, ed, addr, wd;
    logic [3:0] s;
    int choice;
    for (int p = 0; p < NPORTS; p++) begin
      do_access(BASE + p*PORT_STRIDE + 32'h0C, 1, 0, 4'hF, a, e, d, ea, ee, ed);
      do_access(BASE + p*PORT_STRIDE + 32'h10, 1, 0, 4'hF, a, e, d, ea, ee, ed);
      do_access(BASE + p*PORT_STRIDE + 32'h14, 1, 32'hFFFF_FFFF, 4'hF, a, e, d, ea, ee, ed);
    end
    for (int p = 0; p < NPORTS; p++) gpio_i[p*32 +: 32] = $urandom;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      choice = $urandom_range(0, 9);
      addr = BASE | {20'h0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, NPORTS-1)),
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (choice == 0) addr = addr ^ (32'h1 << $urandom_range(12, 31));
      if (choice == 1) addr[7:5] = 3'($urandom_range(NPORTS, 7));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      s  = 4'($urandom_range(0, 15));
      do_access(addr, w, wd, s, a, e, d, ea, ee, ed);
      tests_run++;
      if (a !== ea || e !== ee) begin
        tests_failed++;
        $display("FAIL rand_resp i=%0d adr=%h got ack=%b err=%b expected ack=%b err=%b", i, addr, a, e, ea, ee);
      end
      if (!w && ea) begin
        tests_run++;
        if (d !== ed) begin
          tests_failed++;
          $display("FAIL rand_read i=%0d adr=%h got %h expected %h", i, addr, d, ed);
        end
      end
      tests_run++;
      if (gpio_o !== exp_gpio_o() || gpio_oe_o !== exp_gpio_oe()) begin
        tests_failed++;
        $display("FAIL rand_pins i=%0d got out=%h oe=%h expected out=%h oe=%h",
                 i, gpio_o, gpio_oe_o, exp_gpio_o(), exp_gpio_oe());
      end
    end
  endtask

  task automatic test_edge();
    logic a, e, ea, ee;
    logic [31:0] d, ed, ev, nv;
    do_access(BASE + 32'h0C, 1, 32'h0, 4'hF, a, e, d, ea, ee, ed);
    do_access(BASE + 32'h10, 1, 32'h8, 4'hF, a, e, d, ea, ee, ed);
    do_access(BASE + 32'h14, 1, 32'hFFFF_FFFF, 4'hF, a, e, d, ea, ee, ed);
    nv = gpio_i[31:0]; nv[3] = 1'b1;
    m_status[0] |= pad_events(gpio_i[31:0], nv, 0);
    gpio_i[31:0] = nv;
    repeat (5) @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_idle_irq got %b expected 0", irq);
    end
    // falling edge on bit 3, counted from the edge
    nv[3] = 1'b0;
    ev = pad_events(gpio_i[31:0], nv, 0);
    gpio_i[31:0] = nv;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k >= 3) begin
        tests_run++;
        if (irq !== (k == 4)) begin
          tests_failed++;
          $display("FAIL edge_latency k=%0d got irq=%b expected %b", k, irq, (k == 4));
        end
      end
    end
    m_status[0] |= ev;
    @(negedge clk);
    do_access(BASE + 32'h14, 0, 0, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (d !== ed || ed !== 32'h8) begin
      tests_failed++;
      $display("FAIL edge_status got %h expected %h", d, ed);
    end
    // W1C, then irq falls one cycle after the clearing write
    model_access(BASE + 32'h14, 1, 32'h8, 4'hF, ea, ee, ed);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h14; dat_w = 32'h8; sel = 4'hF;
    @(posedge clk); #1;
    tests_run++;
    if (ack !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1c_cycle got ack=%b irq=%b expected ack=1 irq=1", ack, irq);
    end
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_irq got irq=%b expected 0", irq);
    end
    @(negedge clk);
    do_access(BASE + 32'h14, 0, 0, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (d !== ed || ed !== 32'h0) begin
      tests_failed++;
      $display("FAIL w1c_status got %h expected %h", d, ed);
    end
    // edge landing on the same cycle as the W1C
    nv[3] = 1'b1;
    m_status[0] |= pad_events(gpio_i[31:0], nv, 0);
    gpio_i[31:0] = nv;
    repeat (5) @(negedge clk);
    nv[3] = 1'b0;
    ev = pad_events(gpio_i[31:0], nv, 0);
    gpio_i[31:0] = nv;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_access(BASE + 32'h14, 1, 32'h8, 4'hF, a, e, d, ea, ee, ed);
    m_status[0] |= ev;
    do_access(BASE + 32'h14, 0, 0, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (d !== ed || ed !== 32'h8) begin
      tests_failed++;
      $display("FAIL w1c_race got %h expected %h", d, ed);
    end
  endtask

  task automatic test_err();
    logic a, e, an, en, ea, ee;
    logic [31:0] d, ed;
    logic [31:0] bad [3];
    bad[0] = 32'h1001_0040; bad[1] = 32'h1002_0000; bad[2] = 32'h1001_00E0;
    for (int i = 0; i < 3; i++) begin
      model_access(bad[i], 1, 32'hFFFF_FFFF, 4'hF, ea, ee, ed);
      bus_xfer(bad[i], 1, 32'hFFFF_FFFF, 4'hF, a, e, d, an, en);
      $display("[TB] WR adr=%h dat=ffffffff sel=1111 -> ack=%b err=%b rdat=%h", bad[i], a, e, d);
      tests_run++;
      if (e !== 1'b1 || a !== 1'b0 || en !== 1'b0 || an !== 1'b0 || ee !== 1'b1) begin
        tests_failed++;
        $display("FAIL err_resp adr=%h got ack=%b err=%b next ack=%b err=%b expected err pulse only",
                 bad[i], a, e, an, en);
      end
    end
    do_access(32'h1002_0000, 0, 0, 4'hF, a, e, d, ea, ee, ed);
    tests_run++;
    if (e !== 1'b1 || a !== 1'b0 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL err_read got ack=%b err=%b dat=%h expected ack=0 err=1 dat=0", a, e, d);
    end
    for (int p = 0; p < NPORTS; p++) begin
      for (int r = 0; r < 6; r++) begin
        do_access(BASE + p*PORT_STRIDE + 32'(r*4), 0, 0, 4'hF, a, e, d, ea, ee, ed);
        tests_run++;
        if (d !== ed || a !== 1'b1) begin
          tests_failed++;
          $display("FAIL err_untouched p=%0d r=%0d got %h expected %h", p, r, d, ed);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ack_seen;
    logic [31:0] dat_seen [4];
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h20; sel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      ack_seen[k] = ack;
      dat_seen[k] = dat_r;
      if (k < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    $display("[TB] RD burst adr=%h acks=%b", adr, ack_seen);
    tests_run++;
    if (ack_seen !== 4'b1010) begin
      tests_failed++;
      $display("FAIL b2b_ack got %b (k3..k0) expected 1010", ack_seen);
    end
    tests_run++;
    if (dat_seen[1] !== m_out[1] || dat_seen[3] !== m_out[1] || dat_seen[0] !== 0 || dat_seen[2] !== 0) begin
      tests_failed++;
      $display("FAIL b2b_data got %h %h %h %h expected 0 %h 0 %h",
               dat_seen[0], dat_seen[1], dat_seen[2], dat_seen[3], m_out[1], m_out[1]);
    end
    // reset lands inside an ack cycle
    rst_n = 0;
    #1;
    tests_run++;
    if (ack !== 0 || err !== 0 || dat_r !== 0 || gpio_o !== '0 || gpio_oe_o !== '0 || irq !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset got ack=%b err=%b dat=%h out=%h oe=%h irq=%b expected all 0",
               ack, err, dat_r, gpio_o, gpio_oe_o, irq);
    end
    cyc = 0; stb = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_byte_sel();
    test_random();
    test_edge();
    test_err();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
